// File: rtl/tail_light_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tail_light_pkg
// Description : Shared encodings for the tail-light sequencer: grant/mode
//               codes, per-step LED cluster patterns, 7-segment glyphs and
//               small lookup helpers used by the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package tail_light_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'b00,
        MODE_RIGHT  = 2'b01,
        MODE_LEFT   = 2'b10,
        MODE_HAZARD = 2'b11
    } mode_t;

    // Cluster patterns indexed by step. PAT_RIGHT drives led[2:0],
    // PAT_LEFT drives led[9:7] (bit 9 lights first).
    localparam logic [2:0] PAT_RIGHT [0:3] = '{3'b001, 3'b011, 3'b111, 3'b000};
    localparam logic [2:0] PAT_LEFT  [0:3] = '{3'b100, 3'b110, 3'b111, 3'b000};
    localparam logic [2:0] PAT_HAZ_ON      = 3'b111;

    // Active-low 7-segment glyphs, bit order {dp, g, f, e, d, c, b, a}.
    localparam logic [7:0] C_GLYPH_BLANK  = 8'b1111_1111;
    localparam logic [7:0] C_GLYPH_IDLE   = 8'b1011_1111;  // "-"
    localparam logic [7:0] C_GLYPH_RIGHT  = 8'b1010_1111;  // "r"
    localparam logic [7:0] C_GLYPH_LEFT   = 8'b1100_0111;  // "L"
    localparam logic [7:0] C_GLYPH_HAZARD = 8'b1000_1001;  // "H"

    // Full 10-bit LED word for a given mode and step.
    function automatic logic [9:0] led_pattern(input mode_t m, input logic [1:0] step);
        logic [9:0] v;
        v = '0;
        case (m)
            MODE_RIGHT:  v[2:0] = PAT_RIGHT[step];
            MODE_LEFT:   v[9:7] = PAT_LEFT[step];
            MODE_HAZARD: begin
                // Blink: on for even steps, off for odd steps.
                if (!step[0]) begin
                    v[9:7] = PAT_HAZ_ON;
                    v[2:0] = PAT_HAZ_ON;
                end
            end
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] mode_glyph(input mode_t m);
        logic [7:0] g;
        g = C_GLYPH_BLANK;
        case (m)
            MODE_IDLE:   g = C_GLYPH_IDLE;
            MODE_RIGHT:  g = C_GLYPH_RIGHT;
            MODE_LEFT:   g = C_GLYPH_LEFT;
            MODE_HAZARD: g = C_GLYPH_HAZARD;
            default:     g = C_GLYPH_BLANK;
        endcase
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tail_light_sequencer_tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Free-running 0..TICK_DIV-1 counter that emits a one-cycle
//               tick while the count sits at its terminal value. A
//               synchronous clear restarts the count at 0.
// Ports       : clk     - clock, rising edge
//               reset_n - asynchronous active-low reset
//               clr     - synchronous clear (holds count at 0)
//               tick    - high while count == TICK_DIV-1
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int TICK_DIV = 5000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    output logic tick
);

    localparam int              C_CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(TICK_DIV - 1);

    logic [C_CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clr || (r_count == C_LAST)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/tail_light_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tail_light_sequencer
// Description : Owns the ten red LEDs and shares them between hazard, right
//               turn and left turn by fixed priority (hazard > turn). Each
//               granted mode sweeps or blinks a 4-step pattern, one step per
//               prescaler tick. A grant change restarts the new pattern at
//               step 0 with a fresh prescaler period.
// Ports       : ADC_CLK_10 - system clock
//               reset_n    - asynchronous active-low reset
//               turn_en    - turn enable (async)
//               turn_dir   - 1 = right, 0 = left (async)
//               hazard_en  - hazard enable (async)
//               led[9:0]   - registered LED drive
//               mode[1:0]  - registered grant
//               hex_mode   - registered 7-seg glyph of the grant
//                            (only with TAIL_LIGHT_HEX_EN defined)
//               tick       - one-cycle pulse at each step boundary
// Options     : TAIL_LIGHT_HEX_EN - adds the hex_mode output
// Revision    : 1.0 - initial release
// ============================================================================
module tail_light_sequencer
    import tail_light_pkg::*;
#(
    parameter int TICK_DIV    = 5000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       ADC_CLK_10,
    input  logic       reset_n,
    input  logic       turn_en,
    input  logic       turn_dir,
    input  logic       hazard_en,
    output logic [9:0] led,
    output logic [1:0] mode,
`ifdef TAIL_LIGHT_HEX_EN
    output logic [7:0] hex_mode,
`endif
    output logic       tick
);

    // ------------------------------------------------------------------
    // Input synchronizers, bit order {hazard_en, turn_en, turn_dir}
    // ------------------------------------------------------------------
    logic [2:0] w_async_in;
    logic [2:0] r_sync [SYNC_STAGES];
    logic       s_haz;
    logic       s_turn_en;
    logic       s_dir;

    assign w_async_in = {hazard_en, turn_en, turn_dir};

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
                    if (!reset_n) r_sync[gi] <= '0;
                    else          r_sync[gi] <= w_async_in;
                end
            end else begin : g_rest
                always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
                    if (!reset_n) r_sync[gi] <= '0;
                    else          r_sync[gi] <= r_sync[gi-1];
                end
            end
        end
    endgenerate

    assign s_haz     = r_sync[SYNC_STAGES-1][2];
    assign s_turn_en = r_sync[SYNC_STAGES-1][1];
    assign s_dir     = r_sync[SYNC_STAGES-1][0];

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    mode_t       r_mode;
    logic [1:0]  r_step;
    logic [9:0]  r_led;

    mode_t       w_mode_arb;
    mode_t       w_mode_nxt;
    logic [1:0]  w_step_nxt;
    logic [9:0]  w_led_nxt;
    logic [1:0]  w_step_inc;
    logic        w_change;
    logic        w_tick;
    logic        w_pre_clr;

    // Prescaler restarts on every grant change and is parked in IDLE, so a
    // new pattern always gets a full first step.
    assign w_pre_clr = w_change || (r_mode == MODE_IDLE);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk     (ADC_CLK_10),
        .reset_n (reset_n),
        .clr     (w_pre_clr),
        .tick    (w_tick)
    );

    always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
        if (!reset_n) begin
            r_mode <= MODE_IDLE;
            r_step <= 2'd0;
            r_led  <= '0;
        end else begin
            r_mode <= w_mode_nxt;
            r_step <= w_step_nxt;
            r_led  <= w_led_nxt;
        end
    end

    assign w_step_inc = r_step + 2'd1;

    always_comb begin
        w_mode_arb = MODE_IDLE;
        w_mode_nxt = r_mode;
        w_step_nxt = r_step;
        w_led_nxt  = r_led;
        w_change   = 1'b0;

        if (s_haz)          w_mode_arb = MODE_HAZARD;
        else if (s_turn_en) w_mode_arb = s_dir ? MODE_RIGHT : MODE_LEFT;
        else                w_mode_arb = MODE_IDLE;

        w_change = (w_mode_arb != r_mode);

        // A grant change takes priority over a coincident tick.
        if (w_change) begin
            w_mode_nxt = w_mode_arb;
            w_step_nxt = 2'd0;
            w_led_nxt  = led_pattern(w_mode_arb, 2'd0);
        end else if (w_tick && (r_mode != MODE_IDLE)) begin
            w_step_nxt = w_step_inc;
            w_led_nxt  = led_pattern(r_mode, w_step_inc);
        end
    end

    assign led  = r_led;
    assign mode = r_mode;
    // Prescaler count is parked at 0 in IDLE and under reset, so this is
    // only ever high in an active mode.
    assign tick = w_tick && (r_mode != MODE_IDLE);

`ifdef TAIL_LIGHT_HEX_EN
    logic [7:0] r_hex;

    always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
        if (!reset_n) r_hex <= C_GLYPH_BLANK;
        else          r_hex <= mode_glyph(w_mode_nxt);
    end

    assign hex_mode = r_hex;
`endif

endmodule
`default_nettype wire
